// File: rtl/hex_entry_loader_pkg.sv
// Shared constants for the terminal entry blocks: PS/2 make-codes, terminal
// mode encodings, key classes and the loader state type.
package hex_entry_loader_pkg;

  localparam logic [7:0] SC_0     = 8'h45;
  localparam logic [7:0] SC_1     = 8'h16;
  localparam logic [7:0] SC_2     = 8'h1E;
  localparam logic [7:0] SC_3     = 8'h26;
  localparam logic [7:0] SC_4     = 8'h25;
  localparam logic [7:0] SC_5     = 8'h2E;
  localparam logic [7:0] SC_6     = 8'h36;
  localparam logic [7:0] SC_7     = 8'h3D;
  localparam logic [7:0] SC_8     = 8'h3E;
  localparam logic [7:0] SC_9     = 8'h46;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_B     = 8'h32;
  localparam logic [7:0] SC_C     = 8'h21;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_E     = 8'h24;
  localparam logic [7:0] SC_F     = 8'h2B;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_BKSP  = 8'h66;
  localparam logic [7:0] SC_R     = 8'h2D;

  localparam logic [2:0] MODE_IDLE  = 3'd0;
  localparam logic [2:0] MODE_LOAD  = 3'd1;
  localparam logic [2:0] MODE_ALU   = 3'd2;
  localparam logic [2:0] MODE_BENCH = 3'd3;

  typedef enum logic [2:0] {
    KC_NONE  = 3'd0,
    KC_HEX   = 3'd1,
    KC_ENTER = 3'd2,
    KC_BKSP  = 3'd3,
    KC_RUN   = 3'd4
  } key_class_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ENTRY = 2'd1,
    ST_WRITE = 2'd2
  } state_t;

endpackage

// File: rtl/hex_entry_loader_ps2_hex_decode.sv
// Combinational PS/2 make-code classifier: key class plus hex nibble value.
module ps2_hex_decode
  import hex_entry_loader_pkg::*;
(
  input  logic [7:0]  key,
  output key_class_t  key_class,
  output logic [3:0]  nibble
);

  always_comb begin
    key_class = KC_HEX;
    nibble    = 4'h0;
    case (key)
      SC_0:     nibble = 4'h0;
      SC_1:     nibble = 4'h1;
      SC_2:     nibble = 4'h2;
      SC_3:     nibble = 4'h3;
      SC_4:     nibble = 4'h4;
      SC_5:     nibble = 4'h5;
      SC_6:     nibble = 4'h6;
      SC_7:     nibble = 4'h7;
      SC_8:     nibble = 4'h8;
      SC_9:     nibble = 4'h9;
      SC_A:     nibble = 4'hA;
      SC_B:     nibble = 4'hB;
      SC_C:     nibble = 4'hC;
      SC_D:     nibble = 4'hD;
      SC_E:     nibble = 4'hE;
      SC_F:     nibble = 4'hF;
      SC_ENTER: key_class = KC_ENTER;
      SC_BKSP:  key_class = KC_BKSP;
      SC_R:     key_class = KC_RUN;
      default:  key_class = KC_NONE;
    endcase
  end

endmodule

// File: rtl/hex_entry_loader.sv
// Keyboard-to-memory loader: assembles hex digits into words and writes them
// to consecutive memory addresses on Enter.
module hex_entry_loader
  import hex_entry_loader_pkg::*;
#(
  parameter int unsigned DIGITS     = 4,
  parameter int unsigned AW         = 12,
  parameter logic [2:0]  LOAD_MODE  = 3'd1,
  parameter int unsigned START_ADDR = 0,
  localparam int unsigned DW        = 4 * DIGITS,
  localparam int unsigned EDW       = $clog2(DIGITS + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [2:0]     mode,
  input  logic [7:0]     key,
  input  logic           key_valid,
  output logic [AW-1:0]  mem_addr,
  output logic [DW-1:0]  mem_wdata,
  output logic           mem_we,
  output logic           run_pulse,
  output logic [DW-1:0]  entry_value,
  output logic [EDW-1:0] entry_digits,
  output logic [AW-1:0]  next_addr,
  output logic           full,
  output logic           err
);

  localparam logic [AW-1:0]  START    = AW'(START_ADDR);
  localparam logic [EDW-1:0] MAX_DIGS = EDW'(DIGITS);

  state_t         state, state_n;
  key_class_t     key_class;
  logic [3:0]     nibble;
  logic [DW-1:0]  ev_n, wd_n;
  logic [EDW-1:0] ed_n;
  logic [AW-1:0]  na_n, ma_n;
  logic           full_n, we_q, we_n, run_n, err_n;

  ps2_hex_decode u_decode (
    .key       (key),
    .key_class (key_class),
    .nibble    (nibble)
  );

  // Reset on the WRITE cycle's edge must also hide the strobe already showing.
  assign mem_we = we_q & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      entry_value  <= '0;
      entry_digits <= '0;
      next_addr    <= START;
      full         <= 1'b0;
      mem_addr     <= START;
      mem_wdata    <= '0;
      we_q         <= 1'b0;
      run_pulse    <= 1'b0;
      err          <= 1'b0;
    end else begin
      state        <= state_n;
      entry_value  <= ev_n;
      entry_digits <= ed_n;
      next_addr    <= na_n;
      full         <= full_n;
      mem_addr     <= ma_n;
      mem_wdata    <= wd_n;
      we_q         <= we_n;
      run_pulse    <= run_n;
      err          <= err_n;
    end
  end

  always_comb begin
    state_n = state;
    ev_n    = entry_value;
    ed_n    = entry_digits;
    na_n    = next_addr;
    full_n  = full;
    ma_n    = mem_addr;
    wd_n    = mem_wdata;
    we_n    = 1'b0;
    run_n   = 1'b0;
    err_n   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (mode == LOAD_MODE) begin
          state_n = ST_ENTRY;
          ev_n    = '0;
          ed_n    = '0;
          na_n    = START;
          full_n  = 1'b0;
        end
      end
      default: begin
        if (mode != LOAD_MODE) begin
          state_n = ST_IDLE;
          ev_n    = '0;
          ed_n    = '0;
        end else begin
          state_n = ST_ENTRY;
          // Entry was cleared when WRITE was entered; the address advances as
          // WRITE ends so that mem_addr == next_addr throughout the strobe.
          if (state == ST_WRITE) begin
            if (next_addr == '1) full_n = 1'b1;
            else                 na_n   = next_addr + 1'b1;
          end
          if (key_valid) begin
            case (key_class)
              KC_HEX: begin
                if (entry_digits < MAX_DIGS) begin
                  ev_n = (entry_value << 4) | DW'(nibble);
                  ed_n = entry_digits + 1'b1;
                end else begin
                  err_n = 1'b1;
                end
              end
              KC_BKSP: begin
                if (entry_digits != '0) begin
                  ev_n = entry_value >> 4;
                  ed_n = entry_digits - 1'b1;
                end else begin
                  err_n = 1'b1;
                end
              end
              KC_ENTER: begin
                if (entry_digits != '0) begin
                  if (full) begin
                    err_n = 1'b1;
                  end else begin
                    state_n = ST_WRITE;
                    we_n    = 1'b1;
                    ma_n    = next_addr;
                    wd_n    = entry_value;
                    ev_n    = '0;
                    ed_n    = '0;
                  end
                end
              end
              KC_RUN: begin
                run_n  = 1'b1;
                ev_n   = '0;
                ed_n   = '0;
                na_n   = START;
                full_n = 1'b0;
              end
              default: ;
            endcase
          end
        end
      end
    endcase
  end

endmodule

// File: tb/tb_hex_entry_loader.sv
// Randomised scoreboard bench for hex_entry_loader (DIGITS=4, AW=2).
module tb_hex_entry_loader;

  localparam int DIGITS = 4;
  localparam int AW     = 2;
  localparam int DW     = 16;
  localparam int EDW    = 3;
  localparam logic [2:0] LOAD  = 3'd1;
  localparam logic [2:0] OTHER = 3'd2;
  localparam logic [7:0] K_ENTER = 8'h5A;
  localparam logic [7:0] K_BKSP  = 8'h66;
  localparam logic [7:0] K_R     = 8'h2D;
  localparam int MAX_ADDR = (1 << AW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst = 1'b1;
  logic [2:0]     mode = 3'd0;
  logic [7:0]     key = 8'h00;
  logic           key_valid = 1'b0;
  logic [AW-1:0]  mem_addr;
  logic [DW-1:0]  mem_wdata;
  logic           mem_we;
  logic           run_pulse;
  logic [DW-1:0]  entry_value;
  logic [EDW-1:0] entry_digits;
  logic [AW-1:0]  next_addr;
  logic           full;
  logic           err;

  hex_entry_loader #(
    .DIGITS(DIGITS), .AW(AW), .LOAD_MODE(LOAD), .START_ADDR(0)
  ) dut (
    .clk(clk), .rst(rst), .mode(mode), .key(key), .key_valid(key_valid),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .run_pulse(run_pulse), .entry_value(entry_value),
    .entry_digits(entry_digits), .next_addr(next_addr), .full(full), .err(err)
  );

  typedef struct { int kind; int addr; int data; } ev_t;  // kind: 0 write, 1 run, 2 err
  ev_t q[$];

  int compared = 0;
  int mismatched = 0;

  logic [7:0] hex_codes [16] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
                                 8'h3E, 8'h46, 8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B};

  // Reference model: the word as an integer plus a digit count.
  int m_ev, m_ed, m_addr;
  bit m_full, active;

  task automatic check(input string name, input longint act, input longint exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int nib_of(input logic [7:0] k);
    for (int i = 0; i < 16; i++) if (hex_codes[i] == k) return i;
    return -1;
  endfunction

  function automatic void push(input int kind, input int addr, input int data);
    ev_t e;
    e.kind = kind; e.addr = addr; e.data = data;
    q.push_back(e);
  endfunction

  function automatic void model_key(input logic [7:0] k);
    int n;
    n = nib_of(k);
    if (n >= 0) begin
      if (m_ed < DIGITS) begin m_ev = m_ev * 16 + n; m_ed++; end
      else push(2, 0, 0);
    end else if (k == K_BKSP) begin
      if (m_ed > 0) begin m_ev = m_ev / 16; m_ed--; end
      else push(2, 0, 0);
    end else if (k == K_ENTER) begin
      if (m_ed > 0) begin
        if (m_full) push(2, 0, 0);
        else begin
          push(0, m_addr, m_ev);
          m_ev = 0; m_ed = 0;
          if (m_addr == MAX_ADDR) m_full = 1;
          else m_addr++;
        end
      end
    end else if (k == K_R) begin
      push(1, 0, 0);
      m_ev = 0; m_ed = 0; m_addr = 0; m_full = 0;
    end
  endfunction

  task automatic step(input logic [2:0] m, input bit kv, input logic [7:0] k);
    mode = m; key_valid = kv; key = k;
    if (m != LOAD) begin
      m_ev = 0; m_ed = 0;
    end else if (!active) begin
      m_ev = 0; m_ed = 0; m_addr = 0; m_full = 0;
    end else if (kv) begin
      model_key(k);
    end
    active = (m == LOAD);
    @(posedge clk); #1;
  endtask

  task automatic press(input logic [7:0] k);
    step(LOAD, 1'b1, k);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(LOAD, 1'b0, 8'h00);
  endtask

  task automatic hexkey(input int n);
    press(hex_codes[n]);
  endtask

  task automatic check_state(input string tag);
    check({tag, "_entry_value"},  entry_value,  m_ev);
    check({tag, "_entry_digits"}, entry_digits, m_ed);
    check({tag, "_next_addr"},    next_addr,    m_addr);
    check({tag, "_full"},         full,         m_full);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_mem_we"},       mem_we,       0);
    check({tag, "_run_pulse"},    run_pulse,    0);
    check({tag, "_err"},          err,          0);
    check({tag, "_entry_value"},  entry_value,  0);
    check({tag, "_entry_digits"}, entry_digits, 0);
    check({tag, "_next_addr"},    next_addr,    0);
    check({tag, "_mem_addr"},     mem_addr,     0);
    check({tag, "_full"},         full,         0);
  endtask

  function automatic logic [7:0] rand_key();
    int r;
    logic [7:0] k;
    r = $urandom_range(99);
    if (r < 55)      k = hex_codes[$urandom_range(15)];
    else if (r < 72) k = K_ENTER;
    else if (r < 84) k = K_BKSP;
    else if (r < 88) k = K_R;
    else             k = 8'($urandom);
    return k;
  endfunction

  // Monitor: every output strobe must match the oldest expected event.
  initial begin
    forever begin
      @(negedge clk);
      if (mem_we || run_pulse || err) begin
        ev_t e;
        int kind;
        kind = mem_we ? 0 : (run_pulse ? 1 : 2);
        check("single_strobe", int'(mem_we) + int'(run_pulse) + int'(err), 1);
        if (q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_strobe: got kind %0d, expected no strobe", kind);
        end else begin
          e = q.pop_front();
          check("strobe_kind", kind, e.kind);
          if (kind == 0 && e.kind == 0) begin
            check("mem_addr", mem_addr, e.addr);
            check("mem_wdata", mem_wdata, e.data);
          end
        end
      end
    end
  end

  initial begin
    m_ev = 0; m_ed = 0; m_addr = 0; m_full = 0; active = 0;
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_reset_values("reset");
    rst = 1'b0;

    step(LOAD, 1'b0, 8'h00);
    hexkey(1); hexkey(2); hexkey(3); hexkey(4); press(K_ENTER);
    idle(2);
    check_state("w1234");
    check("w1234_addr_is_1", next_addr, 1);

    hexkey(10); hexkey(11); hexkey(12); hexkey(13); hexkey(14);
    idle(1);
    check("abcd_value", entry_value, 16'hABCD);
    press(K_ENTER); idle(2);

    hexkey(7); hexkey(15); press(K_BKSP); press(K_ENTER); idle(2);
    press(K_BKSP); press(K_ENTER); idle(2);
    check_state("bksp");

    hexkey(1); press(K_ENTER); idle(2);
    check("full_set", full, 1);
    check("full_next_addr", next_addr, 3);
    hexkey(1); press(K_ENTER); idle(2);
    check_state("full_block");
    press(K_R); idle(2);
    check_state("run");

    hexkey(1); hexkey(2);
    step(OTHER, 1'b0, 8'h00); step(OTHER, 1'b0, 8'h00);
    check("idle_digits", entry_digits, 0);
    step(LOAD, 1'b0, 8'h00); idle(1);
    check_state("reenter");

    hexkey(5); step(OTHER, 1'b1, K_ENTER);
    step(LOAD, 1'b0, 8'h00); idle(2);
    check_state("mode_vs_enter");

    for (int i = 0; i < 3000; i++) begin
      int r;
      r = $urandom_range(99);
      if (r < 3)       step(OTHER, 1'($urandom_range(1)), rand_key());
      else if (r < 12) step(LOAD, 1'b0, 8'h00);
      else             step(LOAD, 1'b1, rand_key());
      if (i % 60 == 59) begin
        idle(2);
        check_state("rand");
      end
    end
    idle(3);

    hexkey(9); press(K_ENTER);
    rst = 1'b1;
    #3;
    check("rst_write_suppressed", mem_we, 0);
    if (q.size() > 0) void'(q.pop_back());
    @(posedge clk); #1;
    check_reset_values("rst_mid_write");
    m_ev = 0; m_ed = 0; m_addr = 0; m_full = 0; active = 0;
    rst = 1'b0;
    step(LOAD, 1'b0, 8'h00); idle(3);
    check_state("after_rst");

    check("pending_events", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/hex_entry_loader.md
Name: hex_entry_loader

Overview:
Parametrised keyboard-to-memory loader for the unified terminal. It accepts PS/2 make-codes as one-cycle strobes, assembles hex digits into instruction/data words of configurable width, and writes each word to user memory on Enter. Addresses auto-increment. Backspace, overflow flagging, memory-full protection and a run command are supported. It sits between the PS/2 keyboard front end and the user instruction memory write port, and is active only in the configured load mode.

Parameters:
DIGITS, 4, hex digits per word; word width DW = 4*DIGITS (localparam), range 1..8
AW, 12, memory address width
LOAD_MODE, 3'd1, value of mode in which the block accepts keys
START_ADDR, 0, first write address after reset, run or load-mode entry

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
mode  in  3  terminal mode select
key  in  8  PS/2 make-code, valid only when key_valid=1
key_valid  in  1  one-cycle strobe per keypress
mem_addr  out  AW  write address, held stable while mem_we=1
mem_wdata  out  DW  write data, zero-extended assembled word
mem_we  out  1  one-cycle write strobe
run_pulse  out  1  one-cycle strobe on 'r' key
entry_value  out  DW  word being assembled, for display
entry_digits  out  $clog2(DIGITS+1)  digits currently entered
next_addr  out  AW  address the next Enter will write
full  out  1  last address written; further writes blocked
err  out  1  one-cycle strobe on a rejected key

Behaviour:
- Reset values: all outputs 0; next_addr=mem_addr=START_ADDR; state IDLE.
- States:
  - IDLE: waits for mode==LOAD_MODE, then goes to ENTRY and clears entry, next_addr=START_ADDR, full=0.
  - ENTRY: handles keys.
  - WRITE: one cycle; asserts mem_we, then returns to ENTRY.
- From any non-IDLE state, mode!=LOAD_MODE goes to IDLE the next cycle. The entry is discarded and no write occurs.
- If mode changes in the same cycle as key_valid, the mode change wins and the key is dropped.
- Key decode in ENTRY, acting only when key_valid=1:
  - Hex 0-9 (45,16,1E,26,25,2E,36,3D,3E,46) and A-F (1C,32,21,23,24,2B):
    - if entry_digits<DIGITS: entry_value <= {entry_value[DW-5:0],nibble}; entry_digits+1.
    - else: value unchanged; err pulse.
  - Backspace (66): if entry_digits>0, entry_value >>= 4 and entry_digits-1; else err pulse.
  - Enter (5A):
    - entry_digits==0: ignored, no err.
    - full=1: err pulse, entry retained.
    - otherwise: go to WRITE.
  - 'r' (2D): run_pulse next cycle; entry cleared; next_addr=START_ADDR; full=0.
  - Any other code: ignored, no err.
- WRITE cycle:
  - mem_we=1, mem_addr=next_addr, mem_wdata=entry_value.
  - Entry clears on the same edge.
  - If next_addr==2^AW-1: full<=1 and next_addr holds. Else next_addr+1.
  - Addresses never wrap.
- Latency: key_valid on cycle t gives mem_we, run_pulse or err registered high during cycle t+1.
- key_valid during the WRITE cycle is accepted and processed as in ENTRY. Its effect lands after the write.
- Partial words are right-aligned: Enter after "3F" writes 0x003F (DIGITS=4).
- rst mid-entry or mid-WRITE: the write is suppressed if rst is high on that edge, and all state returns to reset values.
- mem_addr holds its last value when mem_we=0.

Decomposition:
- Shared header (my_header.vh): PS/2 scan-code constants (SC_ENTER, SC_BKSP, SC_R, hex codes), terminal mode encodings, key-class codes (KC_HEX, KC_ENTER, KC_BKSP, KC_RUN, KC_NONE).
- One combinational sub-module: ps2_hex_decode (key -> {class[2:0], nibble[3:0]}). It is reused by future ALU and benchmark entry blocks.

Test Plan:
- Reset, LOAD_MODE, keys 1,2,3,4,Enter -> mem_we at addr 0x000 with data 0x1234; next_addr=1.
- Keys A,B,C,D,E -> fifth digit gives err pulse; entry_value=0xABCD; Enter writes 0xABCD.
- Keys 7,F,Backspace,Enter -> writes 0x0007. Backspace with 0 digits gives err. Enter with 0 digits gives no mem_we and no err.
- AW=2: four Enters of 0x1 -> writes at addr 0..3, then full=1. The fifth Enter gives err and no mem_we. Key 'r' gives run_pulse, full=0, next_addr=0.
- Mode switched away after "12" -> IDLE, no write. Returning to LOAD_MODE gives entry_digits=0 and next_addr=START_ADDR.
- key_valid with Enter and a mode change in the same cycle -> no mem_we. rst asserted during the WRITE cycle -> no mem_we and all outputs at reset values.
